switch_control: RTL and testbench

//  Per-router connection allocator for the Phoenix NoC router. Detects header flits on input buffers,

---
 rtl/switch_control_pkg.sv | 29 ++
 rtl/switch_control_rr_pick.sv | 33 +++
 rtl/switch_control.sv | 181 ++++++++++++++++++
 tb/tb_switch_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_control_pkg.sv
// Shared definitions for the Phoenix NoC router connection allocator.
//   NPORT       : number of router ports (fixed at 5)
//   EAST..LOCAL : port indices used for routing and crossbar selects
//   state_t     : allocator FSM encoding
//   next_port   : wrap-around increment over the port indices
package switch_control_pkg;

  localparam int NPORT = 5;
  localparam int IDX_W = 3;

  localparam logic [IDX_W-1:0] EAST  = 3'd0;
  localparam logic [IDX_W-1:0] WEST  = 3'd1;
  localparam logic [IDX_W-1:0] NORTH = 3'd2;
  localparam logic [IDX_W-1:0] SOUTH = 3'd3;
  localparam logic [IDX_W-1:0] LOCAL = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ROUTE = 3'd2,
    S_GRANT = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] next_port(input logic [IDX_W-1:0] p);
    return (p >= 3'(NPORT - 1)) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/switch_control_rr_pick.sv
// switch_rr_pick: combinational rotating-priority search.
// Ports:
//   req   in  NPORT  request vector
//   last  in  3      index served last; search starts at last+1 and wraps
//   found out 1      at least one request present
//   idx   out 3      first requesting index after last (equals last when none)
module switch_rr_pick
  import switch_control_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = last;
    // Visiting last+1 .. last (wrapped) gives the lowest priority to the
    // input that was served most recently.
    for (int k = 0; k < NPORT; k++) begin
      cand = next_port(cand);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/switch_control.sv
// switch_control: per-router connection allocator for the Phoenix NoC router.
// Detects header flits, picks one requesting input round-robin, XY-routes it,
// reserves the output in the connection table and drives the crossbar selects.
// Connections are released as soon as an input drops its sender flag.
//
// Optional feature macro: SWITCH_CTRL_TIMEOUT_EN
//   defined   : a blocked request gives up after TIMEOUT cycles in S_WAIT so
//               other inputs can be served (8-bit wait counter).
//   undefined : a blocked request waits until its output frees.
//
// Ports:
//   clock    in   1                  rising-edge clock
//   reset    in   1                  synchronous, active-high
//   address  in   2*ADDR_W           this router's {X,Y}
//   h        in   NPORT              header flit waiting on input i
//   data_in  in   NPORT*FLIT_WIDTH   head flit of each input
//   sender   in   NPORT              input i still transferring its packet
//   ack_h    out  NPORT              one-cycle pulse: header of input i accepted
//   free     out  NPORT              output o unallocated
//   mux_in   out  NPORT*3            per output: selected input index
//   mux_out  out  NPORT*3            per input: allocated output index
module switch_control
  import switch_control_pkg::*;
#(
  parameter int FLIT_WIDTH = 16,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [2*ADDR_W-1:0]         address,
  input  logic [NPORT-1:0]            h,
  input  logic [NPORT*FLIT_WIDTH-1:0] data_in,
  input  logic [NPORT-1:0]            sender,
  output logic [NPORT-1:0]            ack_h,
  output logic [NPORT-1:0]            free,
  output logic [NPORT*IDX_W-1:0]      mux_in,
  output logic [NPORT*IDX_W-1:0]      mux_out
);

  state_t              state;
  logic [IDX_W-1:0]    rr;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    target;
  logic [2*ADDR_W-1:0] hdr_addr;
  logic [NPORT-1:0]    connected;
  logic [NPORT-1:0]    ack_q;
  logic [NPORT-1:0]    free_q;
  logic [IDX_W-1:0]    mux_in_q  [NPORT];
  logic [IDX_W-1:0]    mux_out_q [NPORT];
  logic [2*ADDR_W-1:0] flit_addr [NPORT];

  logic [NPORT-1:0]    eligible;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;

`ifdef SWITCH_CTRL_TIMEOUT_EN
  logic [7:0]          wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Only the target-address field of the head flit matters for routing.
  logic unused_data;
  assign unused_data = ^data_in;

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign flit_addr[i]            = data_in[i*FLIT_WIDTH +: 2*ADDR_W];
    assign mux_in[i*IDX_W +: IDX_W]  = mux_in_q[i];
    assign mux_out[i*IDX_W +: IDX_W] = mux_out_q[i];
  end

  assign ack_h    = ack_q;
  assign free     = free_q;
  assign eligible = h & ~connected;

  switch_rr_pick u_pick (
    .req   (eligible),
    .last  (rr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // XY routing: resolve X first, then Y; unsigned coordinate compares.
  function automatic logic [IDX_W-1:0] xy_route(input logic [2*ADDR_W-1:0] here,
                                                input logic [2*ADDR_W-1:0] dest);
    logic [ADDR_W-1:0] lx, ly, tx, ty;
    lx = here[2*ADDR_W-1:ADDR_W];
    ly = here[ADDR_W-1:0];
    tx = dest[2*ADDR_W-1:ADDR_W];
    ty = dest[ADDR_W-1:0];
    if (tx > lx)      return EAST;
    else if (tx < lx) return WEST;
    else if (ty > ly) return NORTH;
    else if (ty < ly) return SOUTH;
    else              return LOCAL;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rr        <= LOCAL;
      sel       <= '0;
      target    <= '0;
      hdr_addr  <= '0;
      connected <= '0;
      ack_q     <= '0;
      free_q    <= '1;
      for (int i = 0; i < NPORT; i++) begin
        mux_in_q[i]  <= '0;
        mux_out_q[i] <= '0;
      end
`ifdef SWITCH_CTRL_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      ack_q <= '0;

      // Release: only allocated outputs are freed here, and a grant only
      // claims an output that is currently free, so the two never collide.
      for (int i = 0; i < NPORT; i++) begin
        if (connected[i] && !sender[i]) begin
          free_q[mux_out_q[i]] <= 1'b1;
          connected[i]         <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (|eligible) state <= S_ARB;
        end

        // ---- arbitration -> route ----
        S_ARB: begin
          if (pick_found) begin
            sel      <= pick_idx;
            hdr_addr <= flit_addr[pick_idx];
            state    <= S_ROUTE;
          end else begin
            state <= S_IDLE;
          end
        end

        // ---- route -> grant ----
        S_ROUTE: begin
          target <= xy_route(address, hdr_addr);
          state  <= S_GRANT;
        end

        // ---- grant / wait ----
        // The registered free value is tested, so an output released this
        // edge is granted one edge later.
        S_GRANT, S_WAIT: begin
          if (free_q[target]) begin
            free_q[target]   <= 1'b0;
            mux_in_q[target] <= sel;
            mux_out_q[sel]   <= target;
            connected[sel]   <= 1'b1;
            ack_q[sel]       <= 1'b1;
            rr               <= sel;
            state            <= S_IDLE;
          end else if (state == S_GRANT) begin
            state <= S_WAIT;
`ifdef SWITCH_CTRL_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            // Give up; moving rr past sel lets the next input be considered.
            rr    <= sel;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Testbench for switch_control: table of routing vectors plus hand-written
// sequences for arbitration order, blocking/release, reset and timeout.
// Expected grants are queued when requests are raised and checked by a
// monitor whenever ack_h pulses.
module tb_switch_control;

  localparam int NP = 5;
  localparam int FW = 16;
  localparam int AW = 4;
`ifdef SWITCH_CTRL_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [2*AW-1:0]  address;
  logic [NP-1:0]    h;
  logic [NP*FW-1:0] data_in;
  logic [NP-1:0]    sender;
  logic [NP-1:0]    ack_h;
  logic [NP-1:0]    free;
  logic [NP*3-1:0]  mux_in;
  logic [NP*3-1:0]  mux_out;

  switch_control #(.FLIT_WIDTH(FW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock   (clk),
    .reset   (rst),
    .address (address),
    .h       (h),
    .data_in (data_in),
    .sender  (sender),
    .ack_h   (ack_h),
    .free    (free),
    .mux_in  (mux_in),
    .mux_out (mux_out)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int port;
    int out;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    int          port;
    logic [15:0] hdr;
    int          out;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[9];

  int checks = 0;
  int errors = 0;
  int ack_count = 0;
  int ack_cycle = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Scoreboard monitor: every ack pulse must match the oldest expected grant.
  always @(negedge clk) begin
    if (ack_h != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack_h=%b with no grant expected", ack_h);
      end else begin
        e_mon = sb.pop_front();
        chk("ack_onehot", int'(ack_h), 1 << e_mon.port);
        chk("ack_mux_out", int'(mux_out[e_mon.port*3 +: 3]), e_mon.out);
        chk("ack_mux_in", int'(mux_in[e_mon.out*3 +: 3]), e_mon.port);
        chk("ack_free_cleared", int'(free[e_mon.out]), 0);
      end
      ack_count++;
      ack_cycle = cycle;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_count < target && n < budget) begin
      tick();
      n++;
    end
    if (ack_count < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timed out, acks=%0d, expected %0d", name, ack_count, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    h = '0;
    sender = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int p, base, h_cycle;

    // {router addr, input, header, expected output}
    vecs[0] = '{8'h11, 4, 16'h0031, 0};  // tx>lx -> EAST
    vecs[1] = '{8'h11, 0, 16'h0001, 1};  // tx<lx -> WEST
    vecs[2] = '{8'h11, 1, 16'h0015, 2};  // X equal, ty>ly -> NORTH
    vecs[3] = '{8'h11, 2, 16'h0010, 3};  // X equal, ty<ly -> SOUTH
    vecs[4] = '{8'h11, 3, 16'h0011, 4};  // same address -> LOCAL
    vecs[5] = '{8'h5A, 4, 16'hFF5A, 4};  // upper flit bits ignored -> LOCAL
    vecs[6] = '{8'h5A, 0, 16'h00F0, 0};  // unsigned X compare -> EAST
    vecs[7] = '{8'h5A, 2, 16'h005F, 2};  // -> NORTH
    vecs[8] = '{8'hF0, 1, 16'h0000, 1};  // -> WEST

    rst = 1'b1;
    address = 8'h11;
    h = '0;
    sender = '0;
    data_in = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset_free", int'(free), 5'h1F);
    chk("reset_ack", int'(ack_h), 0);
    chk("reset_mux_in", int'(mux_in), 0);
    chk("reset_mux_out", int'(mux_out), 0);

    // Routing table: one transaction each, latency and release checked
    for (int v = 0; v < 9; v++) begin
      address = vecs[v].addr;
      p = vecs[v].port;
      data_in[p*FW +: FW] = vecs[v].hdr;
      sb.push_back('{port: p, out: vecs[v].out});
      base = ack_count;
      h[p] = 1'b1;
      sender[p] = 1'b1;
      h_cycle = cycle;
      wait_acks(base + 1, 20, "vec_ack");
      h[p] = 1'b0;
      chk("vec_latency", ack_cycle - h_cycle, 4);
      sender[p] = 1'b0;
      tick();
      tick();
      chk("vec_release_free", int'(free), 5'h1F);
    end

    // Three simultaneous requests: round-robin order 0,2,4 from reset
    do_reset();
    address = 8'h11;
    data_in[0*FW +: FW] = 16'h0031;  // EAST
    data_in[2*FW +: FW] = 16'h0001;  // WEST
    data_in[4*FW +: FW] = 16'h0015;  // NORTH
    sb.push_back('{port: 0, out: 0});
    sb.push_back('{port: 2, out: 1});
    sb.push_back('{port: 4, out: 2});
    base = ack_count;
    h = 5'b10101;
    sender = 5'b10101;
    wait_acks(base + 3, 40, "rr_acks");
    tick();
    chk("rr_free_after", int'(free), 5'b11000);

    // One-cycle reset with three connections open
    rst = 1'b1;
    h = '0;
    sender = '0;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("midreset_free", int'(free), 5'h1F);
    chk("midreset_ack", int'(ack_h), 0);
    chk("midreset_mux_in", int'(mux_in), 0);
    chk("midreset_mux_out", int'(mux_out), 0);
    base = ack_count;
    repeat (6) tick();
    chk("midreset_idle", ack_count, base);
    chk("midreset_free_hold", int'(free), 5'h1F);

    // Blocked request on SOUTH, granted after the holder releases
    address = 8'h11;
    data_in[1*FW +: FW] = 16'h0010;
    sb.push_back('{port: 1, out: 3});
    base = ack_count;
    h[1] = 1'b1;
    sender[1] = 1'b1;
    wait_acks(base + 1, 20, "hold_ack");
    h[1] = 1'b0;
    data_in[3*FW +: FW] = 16'h0010;
    base = ack_count;
    h[3] = 1'b1;
    sender[3] = 1'b1;
    repeat (10) tick();
    chk("blocked_no_ack", ack_count, base);
    sb.push_back('{port: 3, out: 3});
    sender[1] = 1'b0;
    tick();
    chk("release_free_south", int'(free[3]), 1);
    chk("release_no_early_ack", ack_count, base);
`ifndef SWITCH_CTRL_TIMEOUT_EN
    tick();
    chk("grant_after_release", ack_count, base + 1);
`else
    wait_acks(base + 1, 30, "grant_after_release");
`endif
    h[3] = 1'b0;
    sender[3] = 1'b0;
    tick();
    tick();
    chk("blocked_cleanup_free", int'(free), 5'h1F);

    // Input 0 blocked on NORTH with input 1 waiting for WEST
    data_in[2*FW +: FW] = 16'h0015;
    sb.push_back('{port: 2, out: 2});
    base = ack_count;
    h[2] = 1'b1;
    sender[2] = 1'b1;
    wait_acks(base + 1, 20, "north_hold_ack");
    h[2] = 1'b0;
    data_in[0*FW +: FW] = 16'h0015;
    data_in[1*FW +: FW] = 16'h0001;
    base = ack_count;
`ifdef SWITCH_CTRL_TIMEOUT_EN
    sb.push_back('{port: 1, out: 1});
    h[1:0] = 2'b11;
    sender[1:0] = 2'b11;
    h_cycle = cycle;
    wait_acks(base + 1, 30, "timeout_ack");
    chk("timeout_latency", ack_cycle - h_cycle, 12);
    h[1] = 1'b0;
    sb.push_back('{port: 0, out: 2});
`else
    h[1:0] = 2'b11;
    sender[1:0] = 2'b11;
    repeat (30) tick();
    chk("wait_holds_no_ack", ack_count, base);
    sb.push_back('{port: 0, out: 2});
    sb.push_back('{port: 1, out: 1});
`endif
    sender[2] = 1'b0;
    wait_acks(base + 2, 40, "post_release_acks");
    h = '0;
    sender = '0;
    tick();
    tick();
    tick();
    chk("final_free", int'(free), 5'h1F);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected < 20000", cycle);
    $fatal(1, "watchdog");
  end

endmodule
